nonce_mailbox: RTL and testbench

Result-side producer for the interrupt path. Buffers up to two nonces reported by the hashing core, exposes occupancy as the 2-bit `mark_counter` consumed by `irq_gen` (irq asserted while `mark_counter != 2'b10`), and hands buffered nonces to the host through a strobe/valid read port. It sits between the hashing core's found-strobe and the host bus, and is the only driver of `mark_counter`.

---
 rtl/nonce_mailbox.sv | 155 +++++++++++++++
 tb/tb_nonce_mailbox.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_mailbox.sv
// -----------------------------------------------------------------------------
// nonce_mailbox
//
// Two-entry mailbox between the hashing core's found-strobe and the host bus.
// Nonces reported by the core are buffered in a 2-deep FIFO. The host pops
// them through a strobe/valid read port. Occupancy is published on
// mark_counter, which irq_gen watches. irq_gen holds irq high while
// mark_counter != 2'b10.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   found         1-cycle strobe from the hashing core, qualifies nonce_in
//   nonce_in      nonce to store
//   rd_req        1-cycle host read strobe
//   clr_ovf       clears the sticky overflow flag
//   rd_data       popped nonce, meaningful while rd_valid is high
//   rd_valid      1-cycle pulse qualifying rd_data
//   rd_err        1-cycle pulse for a read while empty
//   mark_counter  occupancy code: 2'b10 empty, 2'b00 one, 2'b01 two
//   overflow      sticky: a nonce was dropped because the mailbox was full
//
// Every output is a flop. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module nonce_mailbox #(
  parameter logic [2:0] du      = 3'd1,
  parameter int         NONCE_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               found,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic               rd_req,
  input  logic               clr_ovf,
  output logic [NONCE_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output logic [1:0]         mark_counter,
  output logic               overflow
);

  // du is a simulation delay in the behavioural model this block replaces.
  // The synthesizable implementation applies no delay. The parameter is kept
  // so existing instantiations still elaborate.
  if (du == 3'd0) begin : g_zero_delay
  end

  // Occupancy states are encoded directly as the mark_counter value.
  typedef enum logic [1:0] {
    OCC_ONE   = 2'b00,
    OCC_TWO   = 2'b01,
    OCC_EMPTY = 2'b10,
    OCC_BAD   = 2'b11
  } occ_e;

  occ_e               state_q, state_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [NONCE_W-1:0] slot_q [2];

  logic [1:0]         count;
  logic [1:0]         count_d;
  logic               bad_state;
  logic               do_push, do_pop, drop_push, empty_read;

  logic [NONCE_W-1:0] rd_data_d;
  logic               rd_valid_d, rd_err_d, overflow_d;

  // Decode the current occupancy and the events happening this cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that
    // leaves a signal unassigned would infer a latch.
    count     = 2'd0;
    bad_state = 1'b0;
    unique case (state_q)
      OCC_EMPTY: count = 2'd0;
      OCC_ONE:   count = 2'd1;
      OCC_TWO:   count = 2'd2;
      default:   bad_state = 1'b1;
    endcase

    // A pop frees a slot in the same cycle. A push into a full mailbox
    // therefore succeeds when a pop occurs alongside it.
    do_pop     = rd_req && !bad_state && (count != 2'd0);
    do_push    = found  && !bad_state && ((count != 2'd2) || do_pop);
    drop_push  = found  && !bad_state && (count == 2'd2) && !rd_req;
    empty_read = rd_req && !bad_state && (count == 2'd0);
  end

  // Next-state logic: occupancy and pointers.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count + {1'b0, do_push} - {1'b0, do_pop};

    if (bad_state) begin
      // The unused code recovers to a clean empty mailbox.
      state_d  = OCC_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      unique case (count_d)
        2'd0:    state_d = OCC_EMPTY;
        2'd1:    state_d = OCC_ONE;
        default: state_d = OCC_TWO;
      endcase
    end
  end

  // Output logic: next values of the registered host-side outputs.
  always_comb begin
    rd_valid_d = do_pop;
    rd_err_d   = empty_read;
    rd_data_d  = do_pop ? slot_q[rd_ptr_q] : rd_data;
    // A set in the same cycle as a clear wins.
    overflow_d = drop_push || (overflow && !clr_ovf);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= OCC_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples pre-edge values, whatever order the statements are in.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_data  <= rd_data_d;
      rd_valid <= rd_valid_d;
      rd_err   <= rd_err_d;
      overflow <= overflow_d;
    end
  end

  // Slot storage. When full, a push and a pop hit the same slot. The pop
  // above reads the old contents, because both take effect at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: the slots are deliberately not reset. Occupancy and rd_valid
    // guard every read, so stale contents are never observed.
    if (do_push) slot_q[wr_ptr_q] <= nonce_in;
  end

  assign mark_counter = state_q;

endmodule

// File: tb/tb_nonce_mailbox.sv
// -----------------------------------------------------------------------------
// tb_nonce_mailbox
//
// Scoreboard bench for nonce_mailbox. The driver applies one cycle of
// stimulus. A reference model then steps a plain queue of at most two nonces
// and pushes the expected post-edge outputs into a scoreboard queue. A
// separate monitor pops one expectation after every edge that has one and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_nonce_mailbox;

  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          found;
  logic [NW-1:0] nonce_in;
  logic          rd_req;
  logic          clr_ovf;
  logic [NW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic [1:0]    mark_counter;
  logic          overflow;

  nonce_mailbox #(.NONCE_W(NW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .found        (found),
    .nonce_in     (nonce_in),
    .rd_req       (rd_req),
    .clr_ovf      (clr_ovf),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_err       (rd_err),
    .mark_counter (mark_counter),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected DUT outputs after one clock edge.
  typedef struct {
    logic          valid;
    logic          err;
    logic          ovf;
    logic [1:0]    mark;
    logic [NW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mailbox contents as a queue, plus the sticky flag and
  // the last value the host saw on rd_data.
  logic [NW-1:0] m_fifo[$];
  logic          m_ovf;
  logic [NW-1:0] m_last;

  function automatic logic [1:0] mark_of(input int n);
    case (n)
      0:       return 2'b10;
      1:       return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_ovf  = 1'b0;
    m_last = '0;
  endtask

  task automatic model_step(input logic f, input logic [NW-1:0] n,
                            input logic r, input logic c);
    exp_t e;
    logic dropped;
    e.valid = 1'b0;
    e.err   = 1'b0;
    dropped = 1'b0;
    // The read is served first, so a full mailbox with a read accepts the push.
    if (r) begin
      if (m_fifo.size() == 0) e.err = 1'b1;
      else begin
        e.valid = 1'b1;
        m_last  = m_fifo.pop_front();
      end
    end
    if (f) begin
      if (m_fifo.size() < 2) m_fifo.push_back(n);
      else dropped = 1'b1;
    end
    m_ovf  = dropped | (m_ovf & ~c);
    e.ovf  = m_ovf;
    e.mark = mark_of(m_fifo.size());
    e.data = m_last;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus. Inputs are driven mid-cycle and returned to idle
  // shortly after the edge.
  task automatic cycle(input logic f, input logic [NW-1:0] n,
                       input logic r, input logic c);
    @(negedge clk);
    found    = f;
    nonce_in = n;
    rd_req   = r;
    clr_ovf  = c;
    model_step(f, n, r, c);
    @(posedge clk);
    #2;
    found    = 1'b0;
    nonce_in = '0;
    rd_req   = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compares one expectation per stimulated edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_valid", rd_valid, e.valid);
        check("rd_err", rd_err, e.err);
        check("overflow", overflow, e.ovf);
        check("mark_counter", mark_counter, e.mark);
        check("rd_data", rd_data, e.data);
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    found    = 1'b0;
    nonce_in = '0;
    rd_req   = 1'b0;
    clr_ovf  = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #23;
    check("reset_mark", mark_counter, 2'b10);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_err", rd_err, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_rd_data", rd_data, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    idle(10);
    check("idle_mark", mark_counter, 2'b10);
    check("idle_overflow", overflow, 1'b0);

    // Single nonce, read three cycles later.
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check("one_mark", mark_counter, 2'b00);
    idle(2);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("one_rd_valid", rd_valid, 1'b1);
    check("one_rd_data", rd_data, 32'h1234_5678);
    check("one_back_empty", mark_counter, 2'b10);
    idle(1);
    check("one_valid_drops", rd_valid, 1'b0);

    // Three pushes with no reads: the third is dropped.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    check("full_mark", mark_counter, 2'b01);
    check("full_overflow", overflow, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("full_pop_a", rd_data, 32'hA);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("full_pop_b", rd_data, 32'hB);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("empty_rd_err", rd_err, 1'b1);
    check("empty_rd_valid", rd_valid, 1'b0);
    check("empty_rd_data_held", rd_data, 32'hB);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", overflow, 1'b0);

    // Full mailbox with a push and a pop in the same cycle.
    cycle(1'b1, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 32'h2, 1'b0, 1'b0);
    cycle(1'b1, 32'h3, 1'b1, 1'b0);
    check("swap_rd_data", rd_data, 32'h1);
    check("swap_no_ovf", overflow, 1'b0);
    check("swap_mark", mark_counter, 2'b01);
    // Back-to-back reads.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("swap_pop_2", rd_data, 32'h2);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("swap_pop_3", rd_data, 32'h3);
    check("swap_empty", mark_counter, 2'b10);

    // Empty mailbox with a push and a read together: error, no bypass.
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    check("both_empty_err", rd_err, 1'b1);
    check("both_empty_valid", rd_valid, 1'b0);
    check("both_empty_mark", mark_counter, 2'b00);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("both_empty_next", rd_data, 32'h55);

    // One entry with a push and a pop together.
    cycle(1'b1, 32'h66, 1'b0, 1'b0);
    cycle(1'b1, 32'h77, 1'b1, 1'b0);
    check("one_swap_data", rd_data, 32'h66);
    check("one_swap_mark", mark_counter, 2'b00);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // A drop and a clear in the same cycle leave overflow set.
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 1'b0, 1'b1);
    check("set_beats_clear", overflow, 1'b1);

    // Asynchronous reset mid-cycle while holding two entries.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_mark", mark_counter, 2'b10);
    check("async_overflow", overflow, 1'b0);
    check("async_rd_valid", rd_valid, 1'b0);
    check("async_rd_data", rd_data, '0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_reset_err", rd_err, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 9) < 4), $urandom,
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
    end
    idle(2);

    // Drain whatever remains and confirm the scoreboard emptied.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
